mmult_seq: RTL and testbench

MMULT_SEQ -- requirements
Module: mmult_seq

---
 rtl/mmult_pkg.sv | 10 +
 rtl/mmult_seq_if.sv | 27 ++
 rtl/mmult_elemcnt.sv | 24 ++
 rtl/mmult_seq.sv | 76 +++++++
 tb/tb_mmult_seq.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mmult_pkg.sv
// Shared types and defaults for the MMULT issue sequencer.
package mmult_pkg;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/mmult_seq_if.sv
// GPU-side strobes, memory handshake and address-counter controls of the MMULT sequencer.
interface mmult_seq_if import mmult_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
  logic             mtxc_wr;
  logic [CNT_W:0]   mtxc_din;
  logic             mtxa_wr;
  logic             go;
  logic             mem_ack;
  logic [CNT_W-1:0] mwidth;
  logic             maddw;
  logic             cntld;
  logic             cnten;
  logic             mem_req;
  logic             mac_en;
  logic             mac_first;
  logic             busy;
  logic             done;

  modport master (
    output mtxc_wr, mtxc_din, mtxa_wr, go, mem_ack,
    input  mwidth, maddw, cntld, cnten, mem_req, mac_en, mac_first, busy, done
  );

  modport slave (
    input  mtxc_wr, mtxc_din, mtxa_wr, go, mem_ack,
    output mwidth, maddw, cntld, cnten, mem_req, mac_en, mac_first, busy, done
  );
endinterface

// File: rtl/mmult_elemcnt.sv
// Element counter: clears on issue, advances per accepted operand, flags the last element.
module mmult_elemcnt import mmult_pkg::*; #(parameter int CNT_W = CNT_W_DEF) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] n_m1;

  // Modulo subtraction makes n==0 terminate at all-ones, i.e. 2^CNT_W elements.
  assign n_m1 = n - ONE;
  assign last = (cnt == n_m1);

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl)  cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + ONE;
  end
endmodule

// File: rtl/mmult_seq.sv
// MMULT issue sequencer: fetches N operands on go, drives the MAC and address counter, pulses done.
module mmult_seq import mmult_pkg::*; #(parameter int CNT_W = CNT_W_DEF) (
  input  logic        clk,
  input  logic        resetl,
  mmult_seq_if.slave  bus
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] mwidth_q;
  logic             maddw_q;
  logic [CNT_W-1:0] elem_cnt;
  logic             last;
  logic             idle;
  logic             ack;

  assign idle = (state == IDLE);
  assign ack  = (state == FETCH) && bus.mem_ack;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) state <= IDLE;
    else         state <= state_nxt;
  end

  // Control writes land only while idle so a running sequence keeps its width.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      mwidth_q <= '0;
      maddw_q  <= 1'b0;
    end else if (idle && bus.mtxc_wr) begin
      {maddw_q, mwidth_q} <= bus.mtxc_din;
    end
  end

  mmult_elemcnt #(.CNT_W(CNT_W)) u_elemcnt (
    .clk    (clk),
    .resetl (resetl),
    .clr    (idle && bus.go),
    .en     (ack),
    .n      (mwidth_q),
    .cnt    (elem_cnt),
    .last   (last)
  );

  always_comb begin
    state_nxt     = state;
    bus.cntld     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mac_en    = 1'b0;
    bus.cnten     = 1'b0;
    bus.mac_first = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so the counter never sees a load while the block is held.
        bus.cntld = resetl && bus.mtxa_wr;
        if (bus.go) state_nxt = FETCH;
      end
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.busy      = 1'b1;
        bus.mac_en    = bus.mem_ack;
        bus.cnten     = bus.mem_ack;
        bus.mac_first = bus.mem_ack && (elem_cnt == '0);
        if (bus.mem_ack && last) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mwidth = mwidth_q;
  assign bus.maddw  = maddw_q;
endmodule

// File: tb/tb_mmult_seq.sv
// Directed bench for mmult_seq: issue timing, stalls, busy-time filtering and mid-run reset.
module tb_mmult_seq;
  logic clk = 1'b0;
  logic resetl = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  mmult_seq_if #(.CNT_W(4)) bus ();

  mmult_seq #(.CNT_W(4)) dut (
    .clk    (clk),
    .resetl (resetl),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {bus.mwidth, bus.maddw, bus.cntld, bus.cnten, bus.mem_req,
            bus.mac_en, bus.mac_first, bus.busy, bus.done};
  endfunction

  // Step to just after the next rising edge and return inputs to their quiet values.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.go      = 1'b0;
    bus.mtxa_wr = 1'b0;
    bus.mtxc_wr = 1'b0;
    bus.mem_ack = 1'b1;
  endtask

  task automatic smp();
    #2;
  endtask

  task automatic wr_ctl(input logic [4:0] din);
    cyc();
    bus.mtxc_wr  = 1'b1;
    bus.mtxc_din = din;
    smp();
  endtask

  task automatic issue();
    cyc();
    bus.go = 1'b1;
    smp();
  endtask

  // Runs cycles 1.. after the go cycle until done (bounded), then checks counts and timing.
  task automatic run(input string tag, input int stall_at, input int stall_len,
                     input int exp_n, input int exp_done);
    int macs = 0, cnts = 0, firsts = 0, first_ok = 0, done_k = -1, busy_done = 1, busy1 = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      bus.mem_ack = !(k >= stall_at && k < stall_at + stall_len);
      smp();
      if (k == 1) busy1 = int'(bus.busy);
      if (bus.mac_en) macs++;
      if (bus.cnten) cnts++;
      if (bus.mac_first) begin
        firsts++;
        if (macs == 1) first_ok = 1;
      end
      if (bus.done) begin
        done_k    = k;
        busy_done = int'(bus.busy);
        break;
      end
    end
    chk({tag, "_busy1"}, busy1, 1);
    chk({tag, "_mac_en"}, macs, exp_n);
    chk({tag, "_cnten"}, cnts, exp_n);
    chk({tag, "_first_cnt"}, firsts, 1);
    chk({tag, "_first_pos"}, first_ok, 1);
    chk({tag, "_done_cyc"}, done_k, exp_done);
    chk({tag, "_busy_done"}, busy_done, 0);
  endtask

  initial begin
    int dones;
    bus.go = 1'b0; bus.mtxa_wr = 1'b0; bus.mtxc_wr = 1'b0;
    bus.mem_ack = 1'b0; bus.mtxc_din = '0;
    #3;
    chk("reset_outs", outs(), 12'h000);
    cyc(); cyc();
    resetl = 1'b1;
    smp();
    chk("post_reset_outs", outs(), 12'h000);

    // N=3, continuous ack
    wr_ctl(5'b0_0011);
    chk("cntld_no_mtxa", bus.cntld, 0);
    cyc(); smp();
    chk("mwidth_3", bus.mwidth, 3);
    chk("maddw_0", bus.maddw, 0);
    issue();
    chk("go_cyc_busy", bus.busy, 0);
    run("n3", 0, 0, 3, 4);

    // mwidth 0 means 16 elements
    wr_ctl(5'b0_0000);
    issue();
    run("n16", 0, 0, 16, 17);

    // N=4 with a two-cycle stall
    wr_ctl(5'b0_0100);
    issue();
    run("stall", 2, 2, 4, 7);

    // Writes and go while busy are ignored
    wr_ctl(5'b0_0011);
    issue();
    cyc();
    bus.go = 1'b1; bus.mtxa_wr = 1'b1; bus.mtxc_wr = 1'b1; bus.mtxc_din = 5'h17;
    smp();
    chk("busy_cntld", bus.cntld, 0);
    chk("busy_first", bus.mac_first, 1);
    cyc(); smp();
    chk("busy_mwidth", bus.mwidth, 3);
    chk("busy_mac2", bus.mac_en, 1);
    cyc(); smp();
    cyc(); bus.go = 1'b1; smp();
    chk("busy_done", bus.done, 1);
    chk("busy_done_busy", bus.busy, 0);
    cyc(); smp();
    chk("no_second_busy", bus.busy, 0);
    chk("no_second_done", bus.done, 0);
    chk("no_second_req", bus.mem_req, 0);
    chk("mwidth_kept", bus.mwidth, 3);

    // Address load and go in the same idle cycle
    cyc();
    bus.mtxa_wr = 1'b1; bus.go = 1'b1;
    smp();
    chk("ag_cntld", bus.cntld, 1);
    run("ag", 0, 0, 3, 4);

    // Control write and go in the same cycle use the new width
    cyc();
    bus.mtxc_wr = 1'b1; bus.mtxc_din = 5'b1_0010; bus.go = 1'b1;
    smp();
    run("cg", 0, 0, 2, 3);
    cyc(); smp();
    chk("cg_mwidth", bus.mwidth, 2);
    chk("cg_maddw", bus.maddw, 1);

    // Reset on the second element of N=8
    wr_ctl(5'b0_1000);
    issue();
    cyc(); smp();
    chk("rst_e1_first", bus.mac_first, 1);
    cyc(); smp();
    chk("rst_e2_mac", bus.mac_en, 1);
    resetl = 1'b0;
    #1;
    chk("rst_outs_now", outs(), 12'h000);
    cyc(); smp();
    chk("rst_outs_held", outs(), 12'h000);
    cyc();
    resetl = 1'b1;
    smp();
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(); smp();
      if (bus.done || bus.busy) dones++;
    end
    chk("rst_no_done", dones, 0);
    wr_ctl(5'b0_1000);
    issue();
    run("post_rst", 0, 0, 8, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
